// File: rtl/ccd_sharp_timing_pkg.sv
// Shared types and constants for the Sharp CCD timing generator.
// Holds the FSM states, pixel/line classification codes and the vertical clock patterns.
package ccd_sharp_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XSG,
        ST_VSHIFT,
        ST_HREAD,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PT_NONE  = 2'd0,
        PT_DUMMY = 2'd1,
        PT_BLACK = 2'd2,
        PT_IMAGE = 2'd3
    } pix_type_t;

    typedef enum logic [1:0] {
        LC_DUMMY,
        LC_BLACK,
        LC_IMAGE
    } line_class_t;

    // {xv1,xv2,xv3,xv4}; the rest pattern doubles as the last shift step
    localparam logic [3:0] XV_REST  = 4'b1001;
    localparam logic [3:0] XV_STEP0 = 4'b1100;
    localparam logic [3:0] XV_STEP1 = 4'b0110;
    localparam logic [3:0] XV_STEP2 = 4'b0011;
    localparam logic [3:0] XV_STEP3 = 4'b1001;

    function automatic logic [3:0] xv_step(input logic [1:0] idx);
        logic [3:0] p;
        case (idx)
            2'd0:    p = XV_STEP0;
            2'd1:    p = XV_STEP1;
            2'd2:    p = XV_STEP2;
            default: p = XV_STEP3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ccd_sharp_hline_gen.sv
// Horizontal read-out of one CCD line: two clocks per pixel (h1/rs phase, then h2 phase),
// with a pixel-type tag per column. Outputs are registered; done fires on the last phase-1 clock.
module ccd_sharp_hline_gen
    import ccd_sharp_timing_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 16,
    parameter int BLACK_HFRONT = 2,
    parameter int BLACK_HREAR  = 2,
    parameter int DUMMY_HFRONT = 2,
    parameter int DUMMY_HREAR  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  line_class_t line_class,
    output logic        h1,
    output logic        h2,
    output logic        hl,
    output logic        rs,
    output logic [1:0]  pix_type,
    output logic        done
);

    localparam int PIX = DUMMY_HFRONT + BLACK_HFRONT + IMAGE_WIDTH + BLACK_HREAR + DUMMY_HREAR;
    localparam int PW  = $clog2(PIX + 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);

    localparam int IMG_LO = DUMMY_HFRONT + BLACK_HFRONT;
    localparam int IMG_HI = IMG_LO + IMAGE_WIDTH;

    function automatic logic [1:0] col_type(input line_class_t cls, input int col);
        pix_type_t t;
        if (col < DUMMY_HFRONT || col >= PIX - DUMMY_HREAR || cls == LC_DUMMY)
            t = PT_DUMMY;
        else if (cls == LC_IMAGE && col >= IMG_LO && col < IMG_HI)
            t = PT_IMAGE;
        else
            t = PT_BLACK;
        return t;
    endfunction

    logic          active, active_n;
    logic          phase, phase_n;
    logic [PW-1:0] pix_cnt, pix_cnt_n;
    line_class_t   cls, cls_n;
    logic          h1_n;
    logic [1:0]    pix_type_n;

    assign done = active & phase & (pix_cnt == PIX_LAST);

    always_comb begin
        active_n  = active;
        phase_n   = phase;
        pix_cnt_n = pix_cnt;
        cls_n     = cls;
        if (start) begin
            active_n  = 1'b1;
            phase_n   = 1'b0;
            pix_cnt_n = '0;
            cls_n     = line_class;
        end else if (active) begin
            if (!phase) begin
                phase_n = 1'b1;
            end else if (done) begin
                active_n  = 1'b0;
                phase_n   = 1'b0;
                pix_cnt_n = '0;
            end else begin
                phase_n   = 1'b0;
                pix_cnt_n = pix_cnt + 1'b1;
            end
        end
        // outputs are decoded from the next state so they line up with it after the edge
        h1_n       = active_n & ~phase_n;
        pix_type_n = active_n ? col_type(cls_n, int'(pix_cnt_n)) : PT_NONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            phase    <= 1'b0;
            pix_cnt  <= '0;
            cls      <= LC_DUMMY;
            h1       <= 1'b0;
            h2       <= 1'b1;
            hl       <= 1'b0;
            rs       <= 1'b0;
            pix_type <= PT_NONE;
        end else begin
            active   <= active_n;
            phase    <= phase_n;
            pix_cnt  <= pix_cnt_n;
            cls      <= cls_n;
            h1       <= h1_n;
            h2       <= ~h1_n;
            hl       <= h1_n;
            rs       <= h1_n;
            pix_type <= pix_type_n;
        end
    end

endmodule

// File: rtl/ccd_sharp_timing_gen.sv
// Frame timing for the Sharp CCD: xsg transfer pulse, then per line a 4-step vertical
// shift followed by a horizontal read-out. All pin outputs are registered.
module ccd_sharp_timing_gen
    import ccd_sharp_timing_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 8,
    parameter int BLACK_HFRONT = 2,
    parameter int BLACK_HREAR  = 2,
    parameter int DUMMY_HFRONT = 2,
    parameter int DUMMY_HREAR  = 2,
    parameter int BLACK_VFRONT = 1,
    parameter int BLACK_VREAR  = 1,
    parameter int DUMMY_VFRONT = 1,
    parameter int DUMMY_VREAR  = 1,
    parameter int VSTEP_CLKS   = 4,
    parameter int XSG_CLKS     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_trigger,
    output logic       o_xv1,
    output logic       o_xv2,
    output logic       o_xv3,
    output logic       o_xv4,
    output logic       o_xsg,
    output logic       o_h1,
    output logic       o_h2,
    output logic       o_hl,
    output logic       o_rs,
    output logic [1:0] ov_pix_type,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int LINES = DUMMY_VFRONT + BLACK_VFRONT + IMAGE_HEIGHT + BLACK_VREAR + DUMMY_VREAR;
    localparam int LW = $clog2(LINES + 1);
    localparam int XW = $clog2(XSG_CLKS + 1);
    localparam int VW = $clog2(VSTEP_CLKS + 1);

    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
    localparam logic [XW-1:0] XSG_LAST  = XW'(XSG_CLKS - 1);
    localparam logic [VW-1:0] VCLK_LAST = VW'(VSTEP_CLKS - 1);

    localparam int BLK_LO = DUMMY_VFRONT;
    localparam int IMG_LO = BLK_LO + BLACK_VFRONT;
    localparam int IMG_HI = IMG_LO + IMAGE_HEIGHT;
    localparam int BLK_HI = IMG_HI + BLACK_VREAR;

    state_t        state, state_n;
    logic [XW-1:0] xsg_cnt, xsg_cnt_n;
    logic [VW-1:0] vclk_cnt, vclk_cnt_n;
    logic [1:0]    vstep, vstep_n;
    logic [LW-1:0] line_cnt, line_cnt_n;
    logic          hstart, hdone;
    line_class_t   line_class;

    logic [3:0]    xv_q;
    logic          xsg_q, busy_q, done_q;

    always_comb begin
        if (int'(line_cnt) < BLK_LO || int'(line_cnt) >= BLK_HI)
            line_class = LC_DUMMY;
        else if (int'(line_cnt) >= IMG_LO && int'(line_cnt) < IMG_HI)
            line_class = LC_IMAGE;
        else
            line_class = LC_BLACK;
    end

    always_comb begin
        state_n    = state;
        xsg_cnt_n  = xsg_cnt;
        vclk_cnt_n = vclk_cnt;
        vstep_n    = vstep;
        line_cnt_n = line_cnt;
        hstart     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_trigger) state_n = ST_XSG;
            end
            ST_XSG: begin
                if (xsg_cnt == XSG_LAST) begin
                    state_n    = ST_VSHIFT;
                    xsg_cnt_n  = '0;
                    line_cnt_n = '0;
                end else begin
                    xsg_cnt_n = xsg_cnt + 1'b1;
                end
            end
            ST_VSHIFT: begin
                if (vclk_cnt == VCLK_LAST) begin
                    vclk_cnt_n = '0;
                    if (vstep == 2'd3) begin
                        state_n = ST_HREAD;
                        vstep_n = '0;
                        hstart  = 1'b1;
                    end else begin
                        vstep_n = vstep + 1'b1;
                    end
                end else begin
                    vclk_cnt_n = vclk_cnt + 1'b1;
                end
            end
            ST_HREAD: begin
                if (hdone) begin
                    if (line_cnt == LINE_LAST) begin
                        state_n    = ST_DONE;
                        line_cnt_n = '0;
                    end else begin
                        state_n    = ST_VSHIFT;
                        line_cnt_n = line_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            xsg_cnt  <= '0;
            vclk_cnt <= '0;
            vstep    <= '0;
            line_cnt <= '0;
            xv_q     <= XV_REST;
            xsg_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            xsg_cnt  <= xsg_cnt_n;
            vclk_cnt <= vclk_cnt_n;
            vstep    <= vstep_n;
            line_cnt <= line_cnt_n;
            xv_q     <= (state_n == ST_VSHIFT) ? xv_step(vstep_n) : XV_REST;
            xsg_q    <= (state_n != ST_XSG);
            busy_q   <= (state_n != ST_IDLE);
            done_q   <= (state_n == ST_DONE);
        end
    end

    ccd_sharp_hline_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .BLACK_HFRONT (BLACK_HFRONT),
        .BLACK_HREAR  (BLACK_HREAR),
        .DUMMY_HFRONT (DUMMY_HFRONT),
        .DUMMY_HREAR  (DUMMY_HREAR)
    ) u_hline (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (hstart),
        .line_class (line_class),
        .h1         (o_h1),
        .h2         (o_h2),
        .hl         (o_hl),
        .rs         (o_rs),
        .pix_type   (ov_pix_type),
        .done       (hdone)
    );

    assign {o_xv1, o_xv2, o_xv3, o_xv4} = xv_q;
    assign o_xsg        = xsg_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule
